// File: rtl/data_table_search_chain.sv
// data_table_search_chain: walks one hash-bucket chain in the data RAM per
// task, one outstanding read at a time, and reports FOUND / NO_ENTRY /
// CHAIN_ERROR with the matched value and the number of entries read.
// Optional feature macro: HT_SEARCH_CHAIN_GUARD_EN enables the MAX_HOPS
// chain-length guard; without it the walk runs to match or tail and the hop
// counter saturates.
module data_table_search_chain #(
  parameter int KEY_WIDTH   = 32,
  parameter int VALUE_WIDTH = 32,
  parameter int A_WIDTH     = 8,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_HOPS    = 16,
  localparam int HW         = $clog2(MAX_HOPS + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [KEY_WIDTH-1:0]   task_key_i,
  input  logic [A_WIDTH-1:0]     task_head_ptr_i,
  input  logic                   task_head_ptr_val_i,
  input  logic [TAG_WIDTH-1:0]   task_tag_i,
  input  logic                   task_valid_i,
  output logic                   task_ready_o,
  input  logic                   rd_avail_i,
  output logic                   rd_en_o,
  output logic [A_WIDTH-1:0]     rd_addr_o,
  input  logic                   rd_data_val_i,
  input  logic [KEY_WIDTH-1:0]   rd_key_i,
  input  logic [VALUE_WIDTH-1:0] rd_value_i,
  input  logic [A_WIDTH-1:0]     rd_next_ptr_i,
  input  logic                   rd_next_ptr_val_i,
  output logic [1:0]             result_rescode_o,
  output logic [VALUE_WIDTH-1:0] result_value_o,
  output logic [KEY_WIDTH-1:0]   result_key_o,
  output logic [TAG_WIDTH-1:0]   result_tag_o,
  output logic [HW-1:0]          result_hops_o,
  output logic                   result_valid_o,
  input  logic                   result_ready_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESULT} state_t;
  typedef enum logic [1:0] {RC_FOUND, RC_NO_ENTRY, RC_CHAIN_ERROR} rescode_t;

  state_t                 state_q, state_d;
  rescode_t               rescode_q, rescode_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [VALUE_WIDTH-1:0] value_q, value_d;
  logic [HW-1:0]          hops_q, hops_d;
  logic [A_WIDTH-1:0]     addr_q, addr_d;
  logic [HW-1:0]          hop_inc;

  // Hop count after the entry currently being returned
`ifdef HT_SEARCH_CHAIN_GUARD_EN
  assign hop_inc = hops_q + 1'b1;
`else
  assign hop_inc = (hops_q == '1) ? hops_q : hops_q + 1'b1;
`endif

  // State and task/result registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      rescode_q <= RC_FOUND;
      key_q     <= '0;
      tag_q     <= '0;
      value_q   <= '0;
      hops_q    <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      rescode_q <= rescode_d;
      key_q     <= key_d;
      tag_q     <= tag_d;
      value_q   <= value_d;
      hops_q    <= hops_d;
      addr_q    <= addr_d;
    end
  end

  // Next-state, register updates and the read request
  always_comb begin
    state_d      = state_q;
    rescode_d    = rescode_q;
    key_d        = key_q;
    tag_d        = tag_q;
    value_d      = value_q;
    hops_d       = hops_q;
    addr_d       = addr_q;
    rd_en_o      = 1'b0;
    task_ready_o = (state_q == S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (task_valid_i) begin
          key_d   = task_key_i;
          tag_d   = task_tag_i;
          hops_d  = '0;
          value_d = '0;
          if (!task_head_ptr_val_i) begin
            rescode_d = RC_NO_ENTRY;
            state_d   = S_RESULT;
          end else begin
            addr_d  = task_head_ptr_i;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        rd_en_o = rd_avail_i;
        if (rd_avail_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rd_data_val_i) begin
          hops_d = hop_inc;
          if (rd_key_i == key_q) begin
            rescode_d = RC_FOUND;
            value_d   = rd_value_i;
            state_d   = S_RESULT;
          end else if (!rd_next_ptr_val_i) begin
            rescode_d = RC_NO_ENTRY;
            state_d   = S_RESULT;
`ifdef HT_SEARCH_CHAIN_GUARD_EN
          end else if (hop_inc == HW'(MAX_HOPS)) begin
            rescode_d = RC_CHAIN_ERROR;
            state_d   = S_RESULT;
`endif
          end else begin
            addr_d  = rd_next_ptr_i;
            state_d = S_ISSUE;
          end
        end
      end
      S_RESULT: begin
        if (result_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_addr_o        = addr_q;
  assign result_rescode_o = rescode_q;
  assign result_value_o   = value_q;
  assign result_key_o     = key_q;
  assign result_tag_o     = tag_q;
  assign result_hops_o    = hops_q;
  assign result_valid_o   = (state_q == S_RESULT);

endmodule
